// File: rtl/tdmo_multi_if.sv
// Wishbone slave bus bundle for the TDM serial output block.
// The bus master drives the request side; the TDM block answers with ack/err and read data.
interface tdmo_multi_if;
    logic [31:0] i_wb_adr;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic [31:0] i_wb_dat;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack;
    logic        o_wb_err;

    modport master (
        output i_wb_adr, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb, i_wb_dat,
        input  o_wb_dat, o_wb_ack, o_wb_err
    );

    modport slave (
        input  i_wb_adr, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb, i_wb_dat,
        output o_wb_dat, o_wb_ack, o_wb_err
    );
endinterface

// File: rtl/tdmo_multi.sv
// Parametrised TDM serial output with double-buffered channel words, locked to an
// external serial bit clock and frame sync that are oversampled by the system clock.
module tdmo_multi #(
    parameter int NUM_CH = 32,
    parameter int WORD_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ser_clk,
    input  logic        frame_sync_in,
    output logic        ser_clk_out,
    output logic        data_out,
    output logic        frame_sync_out,
    tdmo_multi_if.slave wb,
    input  logic        scan_in0,
    input  logic        scan_in1,
    input  logic        scan_in2,
    input  logic        scan_in3,
    input  logic        scan_in4,
    input  logic        scan_enable,
    input  logic        test_mode,
    output logic        scan_out0,
    output logic        scan_out1,
    output logic        scan_out2,
    output logic        scan_out3,
    output logic        scan_out4
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BIT_W = $clog2(WORD_W);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0]  CH_ZERO   = CH_W'(0);
    localparam logic [CH_W-1:0]  CH_ONE    = CH_W'(1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_W - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO  = BIT_W'(0);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
    localparam logic [13:0]      NUM_CH_14 = 14'(NUM_CH);
    localparam logic [15:0]      CTRL_ADR  = 16'h0800;
    localparam logic [15:0]      STAT_ADR  = 16'h0804;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [CH_W-1:0]   ch_r, ch_nxt_s, ch_inc_s;
    logic [BIT_W-1:0]  bit_r, bit_nxt_s;
    logic [WORD_W-1:0] word_r, word_nxt_s, first_word_s;
    logic              dout_r, dout_nxt_s;
    logic              fso_r, fso_nxt_s;
    logic [15:0]       fcnt_r, fcnt_nxt_s;
    logic              copy_s;

    logic [WORD_W-1:0] shadow_r [NUM_CH];
    logic [WORD_W-1:0] active_r [NUM_CH];

    logic              en_r, lsb_r, dbuf_r;
    logic              ack_r, err_r;
    logic [31:0]       rdat_r, rd_s;

    logic              s1_r, s2_r, s3_r, f1_r, f2_r, fs_prev_r;
    logic              rise_s, fs_edge_s, last_bit_s, last_ch_s, start_s;

    logic [15:0]       adr_s;
    logic [CH_W-1:0]   wb_ch_s;
    logic              req_s, is_ch_s, is_ctrl_s, is_stat_s, valid_s, wr_s;
    logic              unused_s;

    // Bit index into a word for serial position b, honouring the shift direction.
    function automatic logic pick_bit(input logic [WORD_W-1:0] w,
                                      input logic [BIT_W-1:0]  b,
                                      input logic              lsb);
        logic [BIT_W-1:0] idx;
        idx = lsb ? b : (LAST_BIT - b);
        return w[idx];
    endfunction

    // Two-flop synchroniser plus edge stage for ser_clk; frame sync takes the same path.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r      <= 1'b0;
            s2_r      <= 1'b0;
            s3_r      <= 1'b0;
            f1_r      <= 1'b0;
            f2_r      <= 1'b0;
            fs_prev_r <= 1'b0;
        end else begin
            s1_r <= ser_clk;
            s2_r <= s1_r;
            s3_r <= s2_r;
            f1_r <= frame_sync_in;
            f2_r <= f1_r;
            if (rise_s) begin
                fs_prev_r <= f2_r;
            end else begin
                fs_prev_r <= fs_prev_r;
            end
        end
    end

    assign rise_s      = s2_r & ~s3_r;
    assign fs_edge_s   = rise_s & f2_r & ~fs_prev_r;
    assign last_bit_s  = (bit_r == LAST_BIT);
    assign last_ch_s   = (ch_r == LAST_CH);
    assign ch_inc_s    = ch_r + CH_ONE;
    assign start_s     = en_r & (fs_edge_s | (rise_s & (state_r == RUN) & last_bit_s & last_ch_s));
    // At a DBUF frame start active[0] is being overwritten, so take the incoming shadow value.
    assign first_word_s = dbuf_r ? shadow_r[0] : active_r[0];

    // FSM state and serialiser registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            ch_r    <= CH_ZERO;
            bit_r   <= BIT_ZERO;
            word_r  <= '0;
            dout_r  <= 1'b0;
            fso_r   <= 1'b0;
            fcnt_r  <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            ch_r    <= ch_nxt_s;
            bit_r   <= bit_nxt_s;
            word_r  <= word_nxt_s;
            dout_r  <= dout_nxt_s;
            fso_r   <= fso_nxt_s;
            fcnt_r  <= fcnt_nxt_s;
        end
    end

    // Next-state and next-bit selection.
    always_comb begin
        state_nxt_s = state_r;
        ch_nxt_s    = ch_r;
        bit_nxt_s   = bit_r;
        word_nxt_s  = word_r;
        dout_nxt_s  = dout_r;
        fso_nxt_s   = fso_r;
        fcnt_nxt_s  = fcnt_r;
        copy_s      = 1'b0;
        if (!en_r) begin
            state_nxt_s = IDLE;
            dout_nxt_s  = 1'b0;
            fso_nxt_s   = 1'b0;
        end else if (start_s) begin
            state_nxt_s = RUN;
            ch_nxt_s    = CH_ZERO;
            bit_nxt_s   = BIT_ZERO;
            word_nxt_s  = first_word_s;
            dout_nxt_s  = pick_bit(first_word_s, BIT_ZERO, lsb_r);
            fso_nxt_s   = 1'b1;
            fcnt_nxt_s  = fcnt_r + 16'd1;
            copy_s      = dbuf_r;
        end else begin
            case (state_r)
                RUN: begin
                    if (rise_s && last_bit_s) begin
                        ch_nxt_s   = ch_inc_s;
                        bit_nxt_s  = BIT_ZERO;
                        word_nxt_s = active_r[ch_inc_s];
                        dout_nxt_s = pick_bit(active_r[ch_inc_s], BIT_ZERO, lsb_r);
                        fso_nxt_s  = 1'b0;
                    end else if (rise_s) begin
                        bit_nxt_s  = bit_r + BIT_ONE;
                        dout_nxt_s = pick_bit(word_r, bit_r + BIT_ONE, lsb_r);
                        fso_nxt_s  = 1'b0;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                IDLE: begin
                    dout_nxt_s = 1'b0;
                    fso_nxt_s  = 1'b0;
                end
                default: begin
                    state_nxt_s = IDLE;
                    dout_nxt_s  = 1'b0;
                    fso_nxt_s   = 1'b0;
                end
            endcase
        end
    end

    assign adr_s     = wb.i_wb_adr[15:0];
    assign req_s     = wb.i_wb_cyc & wb.i_wb_stb & ~ack_r & ~err_r;
    assign is_ch_s   = (adr_s[1:0] == 2'b00) && (adr_s[15:2] < NUM_CH_14);
    assign is_ctrl_s = (adr_s == CTRL_ADR);
    assign is_stat_s = (adr_s == STAT_ADR);
    assign valid_s   = is_ch_s | is_ctrl_s | is_stat_s;
    assign wr_s      = req_s & wb.i_wb_we;
    assign wb_ch_s   = adr_s[CH_W+1:2];

    // Read-data multiplexer for the register map.
    always_comb begin
        rd_s = 32'd0;
        if (is_ch_s) begin
            rd_s = 32'(shadow_r[wb_ch_s]);
        end else if (is_ctrl_s) begin
            rd_s = {29'd0, dbuf_r, lsb_r, en_r};
        end else if (is_stat_s) begin
            rd_s = {15'd0, (state_r == RUN), fcnt_r};
        end else begin
            rd_s = 32'd0;
        end
    end

    // Channel storage, control register and Wishbone termination.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_r[i] <= '0;
                active_r[i] <= '0;
            end
            en_r   <= 1'b1;
            lsb_r  <= 1'b0;
            dbuf_r <= 1'b0;
            ack_r  <= 1'b0;
            err_r  <= 1'b0;
            rdat_r <= 32'd0;
        end else begin
            if (copy_s) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    active_r[i] <= shadow_r[i];
                end
            end
            ack_r  <= req_s & valid_s;
            err_r  <= req_s & ~valid_s;
            rdat_r <= (req_s && valid_s && !wb.i_wb_we) ? rd_s : 32'd0;
            if (wr_s && is_ch_s) begin
                shadow_r[wb_ch_s] <= wb.i_wb_dat[WORD_W-1:0];
                if (!dbuf_r) begin
                    active_r[wb_ch_s] <= wb.i_wb_dat[WORD_W-1:0];
                end
            end
            if (wr_s && is_ctrl_s) begin
                en_r   <= wb.i_wb_dat[0];
                lsb_r  <= wb.i_wb_dat[1];
                dbuf_r <= wb.i_wb_dat[2];
            end
        end
    end

    assign ser_clk_out    = s3_r;
    assign data_out       = dout_r;
    assign frame_sync_out = fso_r;
    assign wb.o_wb_ack    = ack_r;
    assign wb.o_wb_err    = err_r;
    assign wb.o_wb_dat    = rdat_r;

    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;

    assign unused_s = ^{wb.i_wb_adr[31:16], wb.i_wb_sel, wb.i_wb_dat, scan_in0, scan_in1,
                        scan_in2, scan_in3, scan_in4, scan_enable, test_mode};
endmodule

// File: tb/tb_tdmo_multi.sv
// Directed bench for tdmo_multi: a 32x8 instance for the main features and a 4x12 instance
// for width/depth and address decode, both driven from a shared serial bit clock.
module tb_tdmo_multi;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, ser_clk, fs1, fs2, tie0;
    logic sco1, dout1, fso1, sco2, dout2, fso2;
    logic [4:0] so1, so2;
    int n_checks, n_errors;

    tdmo_multi_if wb1();
    tdmo_multi_if wb2();

    tdmo_multi u_dut (
        .clk(clk), .reset(reset), .ser_clk(ser_clk), .frame_sync_in(fs1),
        .ser_clk_out(sco1), .data_out(dout1), .frame_sync_out(fso1), .wb(wb1),
        .scan_in0(tie0), .scan_in1(tie0), .scan_in2(tie0), .scan_in3(tie0), .scan_in4(tie0),
        .scan_enable(tie0), .test_mode(tie0),
        .scan_out0(so1[0]), .scan_out1(so1[1]), .scan_out2(so1[2]), .scan_out3(so1[3]),
        .scan_out4(so1[4])
    );

    tdmo_multi #(.NUM_CH(4), .WORD_W(12)) u_dut2 (
        .clk(clk), .reset(reset), .ser_clk(ser_clk), .frame_sync_in(fs2),
        .ser_clk_out(sco2), .data_out(dout2), .frame_sync_out(fso2), .wb(wb2),
        .scan_in0(tie0), .scan_in1(tie0), .scan_in2(tie0), .scan_in3(tie0), .scan_in4(tie0),
        .scan_enable(tie0), .test_mode(tie0),
        .scan_out0(so2[0]), .scan_out1(so2[1]), .scan_out2(so2[2]), .scan_out3(so2[3]),
        .scan_out4(so2[4])
    );

    logic [31:0] xd;
    logic        xa, xe;
    logic        b1_d, b1_f, b2_d, b2_f;
    logic [31:0] cap [32];
    int          cap_fs_n;
    logic        cap_fs0;
    logic [7:0]  ch_val [32];
    logic        acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return {24'd0, r};
    endfunction

    task automatic wb_xfer(input logic sel, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat);
        @(negedge clk);
        if (sel) begin
            wb2.i_wb_adr = adr; wb2.i_wb_dat = dat; wb2.i_wb_we = we;
            wb2.i_wb_cyc = 1'b1; wb2.i_wb_stb = 1'b1;
        end else begin
            wb1.i_wb_adr = adr; wb1.i_wb_dat = dat; wb1.i_wb_we = we;
            wb1.i_wb_cyc = 1'b1; wb1.i_wb_stb = 1'b1;
        end
        @(negedge clk);
        if (sel) begin
            xa = wb2.o_wb_ack; xe = wb2.o_wb_err; xd = wb2.o_wb_dat;
            wb2.i_wb_cyc = 1'b0; wb2.i_wb_stb = 1'b0; wb2.i_wb_we = 1'b0;
        end else begin
            xa = wb1.o_wb_ack; xe = wb1.o_wb_err; xd = wb1.o_wb_dat;
            wb1.i_wb_cyc = 1'b0; wb1.i_wb_stb = 1'b0; wb1.i_wb_we = 1'b0;
        end
    endtask

    task automatic wb_wr(input logic sel, input logic [31:0] adr, input logic [31:0] dat);
        wb_xfer(sel, 1'b1, adr, dat);
        check($sformatf("wr_ack_%0h", adr), {30'd0, xe, xa}, 32'd1);
    endtask

    task automatic wb_rd(input logic sel, input logic [31:0] adr, input string tag,
                         input logic [31:0] exp);
        wb_xfer(sel, 1'b0, adr, 32'd0);
        check({tag, "_ack"}, {30'd0, xe, xa}, 32'd1);
        check(tag, xd, exp);
    endtask

    // One serial bit period; outputs are sampled late in the period, after ser_clk_out falls.
    task automatic ser_bit(input logic sel, input logic fs);
        @(negedge clk);
        if (sel) fs2 = fs; else fs1 = fs;
        ser_clk = 1'b1;
        repeat (4) @(negedge clk);
        ser_clk = 1'b0;
        repeat (4) @(negedge clk);
        b1_d = dout1; b1_f = fso1; b2_d = dout2; b2_f = fso2;
    endtask

    task automatic capture(input logic sel, input int first_ch, input int n_ch, input int w,
                           input int fs_bits);
        int k;
        logic [31:0] word;
        logic d, f;
        k = 0;
        cap_fs_n = 0;
        cap_fs0 = 1'b0;
        for (int c = 0; c < n_ch; c++) begin
            word = 32'd0;
            for (int b = 0; b < w; b++) begin
                ser_bit(sel, k < fs_bits);
                d = sel ? b2_d : b1_d;
                f = sel ? b2_f : b1_f;
                word = {word[30:0], d};
                if (f) cap_fs_n++;
                if (k == 0) cap_fs0 = f;
                k++;
            end
            cap[first_ch + c] = word;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0; n_errors = 0;
        reset = 1'b1; ser_clk = 1'b0; fs1 = 1'b0; fs2 = 1'b0; tie0 = 1'b0;
        wb1.i_wb_adr = 32'd0; wb1.i_wb_sel = 4'hF; wb1.i_wb_we = 1'b0;
        wb1.i_wb_cyc = 1'b0; wb1.i_wb_stb = 1'b0; wb1.i_wb_dat = 32'd0;
        wb2.i_wb_adr = 32'd0; wb2.i_wb_sel = 4'hF; wb2.i_wb_we = 1'b0;
        wb2.i_wb_cyc = 1'b0; wb2.i_wb_stb = 1'b0; wb2.i_wb_dat = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_dout", {31'd0, dout1}, 32'd0);
        check("rst_fso", {31'd0, fso1}, 32'd0);
        check("rst_sco", {31'd0, sco1}, 32'd0);
        check("rst_wb", {wb1.o_wb_dat[29:0], wb1.o_wb_err, wb1.o_wb_ack}, 32'd0);
        check("rst_scan", {27'd0, so1}, 32'd0);
        wb_rd(1'b0, 32'h800, "rst_ctrl", 32'h1);
        wb_rd(1'b0, 32'h804, "rst_status", 32'h0);
        wb_rd(1'b0, 32'h4, "rst_ch1", 32'h0);

        for (int i = 0; i < 32; i++) begin
            ch_val[i] = 8'(8'h5A ^ (i * 29));
            wb_wr(1'b0, 32'(4 * i), {24'hFFFFFF, ch_val[i]});
        end
        wb_rd(1'b0, 32'h1C, "rd_ch7", {24'd0, ch_val[7]});

        // Frame A started by an fs edge, frame B follows without fs.
        capture(1'b0, 0, 32, 8, 1);
        for (int c = 0; c < 32; c++) check($sformatf("A_ch%0d", c), cap[c], {24'd0, ch_val[c]});
        check("A_fs_first", {31'd0, cap_fs0}, 32'd1);
        check("A_fs_count", 32'(cap_fs_n), 32'd1);
        capture(1'b0, 0, 32, 8, 0);
        for (int c = 0; c < 32; c++) check($sformatf("B_ch%0d", c), cap[c], {24'd0, ch_val[c]});
        check("B_fs_first", {31'd0, cap_fs0}, 32'd1);
        check("B_fs_count", 32'(cap_fs_n), 32'd1);
        wb_rd(1'b0, 32'h804, "status_B", 32'h0001_0002);

        // LSB-first frame C.
        wb_wr(1'b0, 32'h800, 32'h3);
        wb_wr(1'b0, 32'hC, 32'h01);
        ch_val[3] = 8'h01;
        capture(1'b0, 0, 32, 8, 0);
        check("lsb_ch3", cap[3], 32'h80);
        check("lsb_ch10", cap[10], rev8(ch_val[10]));
        wb_rd(1'b0, 32'h804, "status_C", 32'h0001_0003);

        // Double-buffered frames n and n+1.
        wb_wr(1'b0, 32'h800, 32'h5);
        wb_wr(1'b0, 32'h14, 32'hAA);
        capture(1'b0, 0, 6, 8, 0);
        wb_wr(1'b0, 32'h14, 32'h55);
        capture(1'b0, 6, 26, 8, 0);
        check("dbuf_n_ch5", cap[5], 32'hAA);
        check("dbuf_n_ch4", cap[4], {24'd0, ch_val[4]});
        wb_rd(1'b0, 32'h804, "status_n", 32'h0001_0004);
        wb_rd(1'b0, 32'h14, "dbuf_shadow", 32'h55);
        capture(1'b0, 0, 32, 8, 0);
        check("dbuf_n1_ch5", cap[5], 32'h55);
        wb_rd(1'b0, 32'h804, "status_n1", 32'h0001_0005);
        ch_val[5] = 8'h55;

        // Resync at ch17 bit 2 with fs held for 8 bits.
        wb_wr(1'b0, 32'h800, 32'h1);
        capture(1'b0, 0, 17, 8, 0);
        check("pre_sync_ch16", cap[16], {24'd0, ch_val[16]});
        ser_bit(1'b0, 1'b0);
        ser_bit(1'b0, 1'b0);
        capture(1'b0, 0, 32, 8, 8);
        for (int c = 0; c < 32; c++) check($sformatf("S_ch%0d", c), cap[c], {24'd0, ch_val[c]});
        check("sync_fs_first", {31'd0, cap_fs0}, 32'd1);
        check("sync_fs_count", 32'(cap_fs_n), 32'd1);
        wb_rd(1'b0, 32'h804, "status_sync", 32'h0001_0007);

        // Unmapped addresses terminate with err and change nothing.
        wb_xfer(1'b0, 1'b1, 32'h808, 32'h0);
        check("err_wr808", {30'd0, xe, xa}, 32'd2);
        wb_xfer(1'b0, 1'b0, 32'h080, 32'h0);
        check("err_rd080", {xd[29:0], xe, xa}, 32'd2);
        wb_rd(1'b0, 32'h800, "ctrl_after_err", 32'h1);

        // 4 x 12 instance.
        wb_wr(1'b1, 32'h8, 32'hABC);
        wb_xfer(1'b1, 1'b1, 32'h10, 32'hFFF);
        check("d2_err010", {30'd0, xe, xa}, 32'd2);
        wb_rd(1'b1, 32'h0, "d2_ch0", 32'h0);
        wb_rd(1'b1, 32'h8, "d2_ch2_rd", 32'hABC);
        capture(1'b1, 0, 4, 12, 1);
        check("d2_ch2", cap[2], 32'hABC);
        check("d2_ch0_ser", cap[0], 32'h0);
        check("d2_fs_first", {31'd0, cap_fs0}, 32'd1);
        check("d2_fs_count", 32'(cap_fs_n), 32'd1);
        capture(1'b1, 0, 4, 12, 0);
        check("d2_wrap_ch2", cap[2], 32'hABC);
        check("d2_wrap_fs", {31'd0, cap_fs0}, 32'd1);
        wb_rd(1'b1, 32'h804, "d2_status", 32'h0001_0002);

        // Reset in the middle of a word.
        wb_wr(1'b0, 32'h0, 32'hFF);
        wb_wr(1'b0, 32'h800, 32'h3);
        ser_bit(1'b0, 1'b1);
        check("pre_rst_bit0", {30'd0, b1_f, b1_d}, 32'd3);
        @(negedge clk);
        fs1 = 1'b0;
        ser_clk = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_rst_bit1", {30'd0, sco1, dout1}, 32'd3);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_outs", {29'd0, sco1, fso1, dout1}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ser_clk = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ser_bit(1'b0, 1'b0);
            acc = acc | b1_d | b1_f;
        end
        check("idle_after_rst", {31'd0, acc}, 32'd0);
        wb_rd(1'b0, 32'h800, "ctrl_after_rst", 32'h1);
        wb_rd(1'b0, 32'h804, "status_after_rst", 32'h0);
        ser_bit(1'b0, 1'b1);
        check("restart_fso", {31'd0, b1_f}, 32'd1);
        wb_rd(1'b0, 32'h804, "status_restart", 32'h0001_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/tdmo_multi.md
# tdmo_multi

Parametrised TDM serial output with double-buffered channel registers. It emits NUM_CH words of WORD_W bits per frame on a serial line, locked to an externally supplied serial bit clock and frame sync. Channel words are written over the Wishbone slave port. It replaces the fixed 32×8 TDM output, adding:
- configurable width and depth;
- LSB/MSB-first ordering;
- frame-atomic updates;
- mid-frame resynchronisation;
- a frame counter.

## Interface
- NUM_CH, 32: channels per frame, 2..512.
- WORD_W, 8: bits per channel word, 4..32.
- clk  in  1  system/Wishbone clock; the only clock; rising edge.
- reset  in  1  synchronous, active-high.
- ser_clk  in  1  serial bit clock, treated as data; f(clk) ≥ 8×f(ser_clk).
- frame_sync_in  in  1  frame start request, sampled at ser_clk rising edges.
- ser_clk_out  out  1  retimed ser_clk, aligned to data_out.
- data_out  out  1  serial data; changes with ser_clk_out rising, valid at its falling edge.
- frame_sync_out  out  1  high during the channel-0 MSB-slot bit period.
- i_wb_adr  in  32  [15:0] byte sub-address; [31:16] ignored.
- i_wb_sel  in  4  ignored.
- i_wb_we, i_wb_cyc, i_wb_stb  in  1  Wishbone controls.
- i_wb_dat  in  32  write data.
- o_wb_dat  out  32  read data.
- o_wb_ack, o_wb_err  out  1  cycle termination.
- scan_in0..4, scan_enable, test_mode (in, 1), scan_out0..4 (out, 1): DFT hooks; scan_outN tied 0.

## Operation
- Address map:
  - 4·ch for ch < NUM_CH: channel word; i_wb_dat[WORD_W-1:0]; reads zero-extend.
  - 0x800 CTRL: bit0 EN (reset 1); bit1 LSB_FIRST (reset 0); bit2 DBUF (reset 0).
  - 0x804 STATUS: read-only; [15:0] frame count; [16] RUN.
  - Any other address returns o_wb_err instead of o_wb_ack. The error cycle has no side effects; read data is 0.
- Storage: shadow[NUM_CH] (Wishbone-visible) and active[NUM_CH] (serialised).
  - DBUF=0: writes update shadow and active together.
  - DBUF=1: writes update shadow only. Every frame start copies all shadow→active in one clk.
  - A write in the copy cycle lands in shadow only and is shifted out next frame.
- ser_clk path: two-flop synchroniser s1,s2, then s3. rise = s2 & ~s3. ser_clk_out = s3.
- FSM:
  - IDLE: data_out=0, frame_sync_out=0.
  - IDLE→RUN on a rise with sampled fs edge (frame_sync_in=1 at this rise, 0 at the previous rise) and EN=1.
  - RUN→IDLE when EN cleared, effective immediately.
- Frame start: an fs edge in any state, or wrap after the last bit of channel NUM_CH-1. At frame start:
  - ch_cnt=0, bit_cnt=0;
  - load channel 0's word;
  - frame count +1 (16-bit, wraps 0xFFFF→0);
  - DBUF copy if DBUF=1.
  - An fs edge mid-word aborts the current word immediately (resync). Holding fs high for several bits does not re-trigger.
- Each rise in RUN drives the next bit:
  - MSB first (or LSB first if LSB_FIRST);
  - after WORD_W bits, advance the channel and load active[ch] (with DBUF=0 and a same-cycle write to that channel, the old value is loaded);
  - after NUM_CH channels, frame start without any fs.
- frame_sync_out = 1 for exactly the bit period of channel 0 bit 0.

## Timing
- Reset values: data_out 0, frame_sync_out 0, ser_clk_out 0, o_wb_ack 0, o_wb_err 0, o_wb_dat 0, FSM IDLE, counters 0, shadow/active 0, CTRL 0x1.
- data_out, frame_sync_out and ser_clk_out all change on the clk edge where s3 rises: 3 clk after the ser_clk rising edge.
- Wishbone:
  - a request is cyc&stb&~ack&~err;
  - ack/err is registered, exactly one clk after the request, one-cycle pulse;
  - write takes effect on the request cycle edge;
  - o_wb_dat is valid with ack;
  - a held request is re-served every second cycle.
- Reset mid-frame: takes effect at the next clk edge. The line goes idle and a fresh fs edge is needed to restart.
- Reset has priority over Wishbone and ser_clk events in the same cycle.

## Test plan
- Default params, DBUF=0, write ch0..31 = random, fs edge once → each 8-bit slot captured on ser_clk_out fall matches, MSB first; frame_sync_out high only in ch0 bit 7 slot; frames repeat without fs.
- LSB_FIRST=1, ch3=0x01 → ch3 slot emits 1,0,0,0,0,0,0,0.
- DBUF=1, ch5=0xAA in frame n, rewrite 0x55 mid-frame n after ch5 slot → frame n shows 0xAA, frame n+1 shows 0x55; STATUS frame count increments by exactly 1 per frame.
- fs edge at random ch/bit (e.g. ch17 bit 2) → next bit is ch0 MSB; frame count +1; fs held high 8 bits gives no second restart.
- NUM_CH=4, WORD_W=12: write 0xABC to ch2 → 12-bit slot 0xABC; wraps after 48 bits; addr 0x010 → o_wb_err, no state change.
- reset asserted mid-word → all outputs 0 the next clk edge; data_out stays 0 until a new fs edge; read of 0x800 returns 0x1.
